// File: rtl/primitive_assembler_if.sv
// Vertex-in / triangle-out bundle for primitive_assembler.
// master = assembler side, slave = producer/consumer side.
interface primitive_assembler_if #(
  parameter int VW = 256
);
  logic          in_valid;
  logic [VW-1:0] in_data;
  logic          tri_valid;
  logic          tri_ready;
  logic [VW-1:0] tri_v0;
  logic [VW-1:0] tri_v1;
  logic [VW-1:0] tri_v2;

  modport master (
    input  in_valid,
    input  in_data,
    input  tri_ready,
    output tri_valid,
    output tri_v0,
    output tri_v1,
    output tri_v2
  );

  modport slave (
    output in_valid,
    output in_data,
    output tri_ready,
    input  tri_valid,
    input  tri_v0,
    input  tri_v1,
    input  tri_v2
  );
endinterface

// File: rtl/primitive_assembler.sv
// Groups IVB vertex records into triangles (list or strip).
// PA_STRIP_EN enables strip topology; otherwise list only.
module primitive_assembler #(
  parameter int VW    = 256,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                reset,
  primitive_assembler_if.master bus,
  input  logic                mode,
  input  logic                restart,
  output logic                overflow,
  output logic [31:0]         tri_count,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_V0,
    S_V1,
    S_V2,
    S_EMIT
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [VW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [VW-1:0] r0;
  logic [VW-1:0] r1;
  logic [VW-1:0] r2;
  logic          restart_pend;
  logic          mode_q;
  logic          parity_q;
  logic          empty;
  logic          push;
  logic          pop;
  logic          fire;
  logic          strip_cont;

  assign empty = (count_q == '0);
  assign fire  = (state_q == S_EMIT)
               && bus.tri_ready;
  assign push  = bus.in_valid
               && ((count_q != FULL) || pop);

  // Strip continues only when no restart
  // is pending or arriving with the accept.
  assign strip_cont = fire && mode_q
                    && !restart
                    && !restart_pend;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_V0, S_V1, S_V2: begin
        if (restart) begin
          state_d = S_V0;
        end else if (!empty) begin
          pop = 1'b1;
          unique case (state_q)
            S_V0:    state_d = S_V1;
            S_V1:    state_d = S_V2;
            default: state_d = S_EMIT;
          endcase
        end
      end
      S_EMIT: begin
        if (fire) begin
          state_d = strip_cont ? S_V2 : S_V0;
        end
      end
      default: state_d = S_V0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_V0;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (bus.in_valid && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else if (pop) begin
      unique case (state_q)
        S_V0:    r0 <= mem[rd_ptr];
        S_V1:    r1 <= mem[rd_ptr];
        default: r2 <= mem[rd_ptr];
      endcase
    end else if (strip_cont) begin
      r0 <= r1;
      r1 <= r2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      restart_pend <= 1'b0;
      tri_count    <= '0;
    end else begin
      if (fire) begin
        restart_pend <= 1'b0;
        tri_count    <= tri_count + 32'd1;
      end else if (restart
                   && state_q == S_EMIT) begin
        restart_pend <= 1'b1;
      end
    end
  end

`ifdef PA_STRIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      if (restart) mode_q <= mode;
      if (fire) begin
        parity_q <= strip_cont
                  ? ~parity_q : 1'b0;
      end else if (restart) begin
        parity_q <= 1'b0;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_q      = 1'b0;
  assign parity_q    = 1'b0;
`endif

  // Odd strip triangles swap v0/v1 to
  // keep a consistent winding order.
  always_comb begin
    bus.tri_v0 = r0;
    bus.tri_v1 = r1;
    bus.tri_v2 = r2;
    if (parity_q) begin
      bus.tri_v0 = r1;
      bus.tri_v1 = r0;
    end
  end

  assign bus.tri_valid = (state_q == S_EMIT);
  assign busy = !empty
              || (state_q != S_V0)
              || restart_pend;

endmodule

// File: tb/tb_primitive_assembler.sv
// Scoreboard bench for primitive_assembler.
// Expectations follow PA_STRIP_EN when defined.
module tb_primitive_assembler;

  localparam int VW = 256;

  typedef struct {
    int a;
    int b;
    int c;
  } tri_t;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        restart;
  logic        overflow;
  logic [31:0] tri_count;
  logic        busy;

  int   n_tests;
  int   n_fail;
  tri_t sb_q[$];

  primitive_assembler_if #(.VW(VW)) bus ();

  primitive_assembler #(
    .VW(VW),
    .DEPTH(16),
    .AW(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mode(mode),
    .restart(restart),
    .overflow(overflow),
    .tri_count(tri_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] vtx(
    input int id
  );
    logic [31:0] w;
    w = 32'(id) ^ 32'h5A5A_0000;
    return {8{w}};
  endfunction

  task automatic check(
    input string         tag,
    input logic [VW-1:0] got,
    input logic [VW-1:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_tri(
    input int a,
    input int b,
    input int c
  );
    tri_t t;
    t.a = a;
    t.b = b;
    t.c = c;
    sb_q.push_back(t);
  endtask

  task automatic push_v(input int id);
    bus.in_valid = 1'b1;
    bus.in_data  = vtx(id);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_restart(input logic m);
    mode    = m;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check(tag, VW'(sb_q.size()), '0);
      sb_q.delete();
    end
    repeat (3) tick();
  endtask

  // Accept happens at the next posedge;
  // inputs are stable across the negedge.
  always @(negedge clk) begin
    if (reset && bus.tri_valid
        && bus.tri_ready) begin
      if (sb_q.size() == 0) begin
        check("extra_tri", 1, 0);
      end else begin
        tri_t t;
        t = sb_q.pop_front();
        check("v0", bus.tri_v0, vtx(t.a));
        check("v1", bus.tri_v1, vtx(t.b));
        check("v2", bus.tri_v2, vtx(t.c));
      end
    end
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    mode          = 1'b0;
    restart       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tri_ready = 1'b0;
    #3;
    check("rst_valid", VW'(bus.tri_valid), 0);
    check("rst_v0", bus.tri_v0, '0);
    check("rst_v2", bus.tri_v2, '0);
    check("rst_ovf", VW'(overflow), 0);
    check("rst_cnt", VW'(tri_count), 0);
    check("rst_busy", VW'(busy), 0);

    // 1: list, back-to-back
    do_reset();
    bus.tri_ready = 1'b1;
    exp_tri(1, 2, 3);
    exp_tri(4, 5, 6);
    for (int i = 1; i <= 6; i++) push_v(i);
    drain("t1_timeout");
    check("t1_cnt", VW'(tri_count), 2);
    check("t1_ovf", VW'(overflow), 0);
    check("t1_busy", VW'(busy), 0);

    // 2: strip
    do_reset();
    bus.tri_ready = 1'b1;
    do_restart(1'b1);
    exp_tri(1, 2, 3);
`ifdef PA_STRIP_EN
    exp_tri(3, 2, 4);
    exp_tri(3, 4, 5);
`endif
    for (int i = 1; i <= 5; i++) push_v(i);
    drain("t2_timeout");
`ifdef PA_STRIP_EN
    check("t2_cnt", VW'(tri_count), 3);
`else
    check("t2_cnt", VW'(tri_count), 1);
`endif
    check("t2_busy", VW'(busy), 1);

    // 3: stall and overflow
    do_reset();
    bus.tri_ready = 1'b0;
    for (int i = 1; i <= 20; i++) push_v(i);
    repeat (3) tick();
    check("t3_hold", VW'(bus.tri_valid), 1);
    check("t3_hv0", bus.tri_v0, vtx(1));
    check("t3_ovf", VW'(overflow), 1);
    check("t3_cnt0", VW'(tri_count), 0);
    for (int i = 0; i < 6; i++) begin
      exp_tri(3*i+1, 3*i+2, 3*i+3);
    end
    bus.tri_ready = 1'b1;
    drain("t3_timeout");
    check("t3_cnt", VW'(tri_count), 6);
    check("t3_busy", VW'(busy), 1);

    // 4: restart discards partial
    do_reset();
    bus.tri_ready = 1'b1;
    push_v(1);
    push_v(2);
    repeat (3) tick();
    check("t4_busy", VW'(busy), 1);
    do_restart(1'b0);
    exp_tri(7, 8, 9);
    push_v(7);
    push_v(8);
    push_v(9);
    drain("t4_timeout");
    check("t4_cnt", VW'(tri_count), 1);
    check("t4_idle", VW'(busy), 0);

    // 5: restart while holding
    do_reset();
    do_restart(1'b1);
    bus.tri_ready = 1'b0;
    push_v(1);
    push_v(2);
    push_v(3);
    repeat (3) tick();
    check("t5_hold", VW'(bus.tri_valid), 1);
    do_restart(1'b1);
    check("t5_still", VW'(bus.tri_valid), 1);
    check("t5_hv0", bus.tri_v0, vtx(1));
    push_v(4);
    push_v(5);
    push_v(6);
    exp_tri(1, 2, 3);
    exp_tri(4, 5, 6);
    bus.tri_ready = 1'b1;
    drain("t5_timeout");
    check("t5_cnt", VW'(tri_count), 2);
`ifdef PA_STRIP_EN
    check("t5_busy", VW'(busy), 1);
`else
    check("t5_busy", VW'(busy), 0);
`endif

    // 6: async reset mid-burst
    do_reset();
    bus.tri_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_v(i);
    bus.in_valid = 1'b1;
    bus.in_data  = vtx(5);
    tick();
    check("t6_hold", VW'(bus.tri_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", VW'(bus.tri_valid), 0);
    check("t6_v0", bus.tri_v0, '0);
    check("t6_v1", bus.tri_v1, '0);
    check("t6_cnt", VW'(tri_count), 0);
    check("t6_busy", VW'(busy), 0);
    check("t6_ovf", VW'(overflow), 0);
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.tri_ready = 1'b1;
    exp_tri(7, 8, 9);
    push_v(7);
    push_v(8);
    push_v(9);
    drain("t6_timeout");
    check("t6_cnt1", VW'(tri_count), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
